// File: rtl/cross_bar_pkg.sv
// -----------------------------------------------------------------------------
// cross_bar_pkg
//   Shared definitions for the 2x2 cross bar: bus widths, command encoding,
//   arbiter state type and the data word returned to a master when the
//   watchdog gives up on a silent slave.
//   Imported by rr_arb2 and slave_port_arbiter.
// -----------------------------------------------------------------------------
package cross_bar_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Arbiter state encoding, kept as plain constants so older tools and
    // waveform scripts can match on the raw bit values.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY
    } arb_state_t;

    // Read data handed to a master whose transfer was cut short by the
    // watchdog; chosen to be easy to spot in memory dumps.
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // After serving the master in one-hot grant 'served', the preference
    // moves to the other master (0 = master 1 preferred, 1 = master 2).
    function automatic logic next_prio(input logic [1:0] served);
        return served[0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Purely combinational two-way round-robin pick. A lone requester always
//   wins; when both request, the preferred one (i_prio) wins.
//   Ports:
//     i_hit  [1:0]  qualified requests, bit0 = master 1, bit1 = master 2
//     i_prio        preferred master on a tie (0 = master 1, 1 = master 2)
//     o_gnt  [1:0]  one-hot pick, 00 when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2
    import cross_bar_pkg::*;
(
    input  logic [1:0] i_hit,
    input  logic       i_prio,
    output logic [1:0] o_gnt
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pick
            // Win if requesting and either the rival is silent or we hold
            // the preference.
            assign o_gnt[gi] = i_hit[gi] & (~i_hit[1-gi] | (i_prio == 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/slave_port_arbiter.sv
// -----------------------------------------------------------------------------
// slave_port_arbiter
//   Sits in front of one slave_ram in the 2x2 cross bar. Decodes which master
//   requests target this slave (addr[SEL_BIT] == SLAVE_ID), grants one of them
//   at a time in round-robin order and muxes the owner's request onto the
//   slave port. The slave's ack/rdata are routed back to the owner only.
//
//   Optional feature (compile-time macro ARB_TIMEOUT_EN):
//     A watchdog counts BUSY cycles; if the slave stays silent for
//     TIMEOUT_CYCLES cycles the owner gets a one-cycle ack with
//     TIMEOUT_RDATA, timeout_flag is set (sticky until reset) and the port is
//     released. Without the macro the port waits for slave_ack indefinitely
//     and timeout_flag is tied low.
//
//   Ports:
//     clk, resetn                 clock, synchronous active-low reset
//     master_x_req/addr/cmd/wdata request from master x (x = 1, 2)
//     master_x_ack/rdata          response to master x
//     slave_req/addr/cmd/wdata    muxed request towards the slave
//     slave_ack/rdata             slave response, ack is a one-cycle pulse
//     grant [1:0]                 one-hot owner, bit0 = master 1
//     timeout_flag                sticky watchdog error
// -----------------------------------------------------------------------------
module slave_port_arbiter
    import cross_bar_pkg::*;
#(
    parameter int SLAVE_ID       = 0,
    parameter int SEL_BIT        = 31,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              master_1_req,
    input  logic [ADDR_W-1:0] master_1_addr,
    input  logic              master_1_cmd,
    input  logic [DATA_W-1:0] master_1_wdata,
    output logic              master_1_ack,
    output logic [DATA_W-1:0] master_1_rdata,

    input  logic              master_2_req,
    input  logic [ADDR_W-1:0] master_2_addr,
    input  logic              master_2_cmd,
    input  logic [DATA_W-1:0] master_2_wdata,
    output logic              master_2_ack,
    output logic [DATA_W-1:0] master_2_rdata,

    output logic              slave_req,
    output logic [ADDR_W-1:0] slave_addr,
    output logic              slave_cmd,
    output logic [DATA_W-1:0] slave_wdata,
    input  logic              slave_ack,
    input  logic [DATA_W-1:0] slave_rdata,

    output logic [1:0]        grant,
    output logic              timeout_flag
);

    localparam logic SEL_VAL = 1'(SLAVE_ID);

    // -------------------------------------------------------------------------
    // Master-side signals packed into arrays indexed 0 = master 1, 1 = master 2
    // -------------------------------------------------------------------------
    logic [1:0]        w_req;
    logic [1:0]        w_cmd;
    logic [1:0]        w_hit;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic [1:0]        w_ack;
    logic [DATA_W-1:0] w_rdata [2];

    assign w_req      = {master_2_req, master_1_req};
    assign w_cmd      = {master_2_cmd, master_1_cmd};
    assign w_addr[0]  = master_1_addr;
    assign w_addr[1]  = master_2_addr;
    assign w_wdata[0] = master_1_wdata;
    assign w_wdata[1] = master_2_wdata;

    assign master_1_ack   = w_ack[0];
    assign master_2_ack   = w_ack[1];
    assign master_1_rdata = w_rdata[0];
    assign master_2_rdata = w_rdata[1];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_next;
    logic        r_prio;
    logic        w_prio_next;

    logic [1:0]        w_pick;
    logic              w_busy;
    logic              w_sel;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_ret_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            // Requests aimed at the other slave are invisible to this port.
            assign w_hit[gi] = w_req[gi] && (w_addr[gi][SEL_BIT] == SEL_VAL);
        end
    endgenerate

    rr_arb2 u_rr_arb2 (
        .i_hit  (w_hit),
        .i_prio (r_prio),
        .o_gnt  (w_pick)
    );

    assign w_busy = (r_state == BUSY);
    // Index of the owner; only meaningful while BUSY (grant is one-hot then).
    assign w_sel  = r_grant[1];

    // -------------------------------------------------------------------------
    // Optional watchdog
    // -------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout_flag;

    // A real slave_ack in the expiry cycle takes precedence over the timeout.
    assign w_timeout = w_busy && !slave_ack && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wdog         <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            // Held at zero in IDLE, so every BUSY period starts counting at 0.
            if (!w_busy) begin
                r_wdog <= '0;
            end else if (r_wdog != WDOG_LAST) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // The owner's transfer ends on a slave ack or on a watchdog expiry.
    assign w_done     = w_busy && (slave_ack || w_timeout);
    assign w_ret_data = w_timeout ? TIMEOUT_RDATA : slave_rdata;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_prio_next  = r_prio;
        case (r_state)
            IDLE: begin
                // Spurious slave_ack here is simply not looked at.
                if (|w_pick) begin
                    w_state_next = BUSY;
                    w_grant_next = w_pick;
                end
            end
            BUSY: begin
                // Owner dropping req is ignored: only completion releases.
                if (w_done) begin
                    w_state_next = IDLE;
                    w_grant_next = 2'b00;
                    w_prio_next  = next_prio(r_grant);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_prio  <= w_prio_next;
        end
    end

    // -------------------------------------------------------------------------
    // Slave-side mux: everything is forced to zero while IDLE
    // -------------------------------------------------------------------------
    assign slave_req   = w_busy;
    assign slave_addr  = w_busy ? w_addr[w_sel]  : '0;
    assign slave_cmd   = w_busy ? w_cmd[w_sel]   : CMD_READ;
    assign slave_wdata = w_busy ? w_wdata[w_sel] : '0;

    // -------------------------------------------------------------------------
    // Response routing: only the owner sees ack/rdata
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign w_ack[gi]   = w_done && r_grant[gi];
            assign w_rdata[gi] = (w_busy && r_grant[gi]) ? w_ret_data : '0;
        end
    endgenerate

    assign grant = r_grant;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_slave_port_arbiter
//   Self-checking bench for slave_port_arbiter (SLAVE_ID=0, SEL_BIT=31,
//   TIMEOUT_CYCLES=8). Directed scenarios plus a randomized run compared
//   against a transaction-level model of owner / preferred master.
//   Timeout scenarios are compiled in when ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slave_port_arbiter;

    localparam int TMO = 8;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        master_1_req, master_1_cmd, master_1_ack;
    logic [31:0] master_1_addr, master_1_wdata, master_1_rdata;
    logic        master_2_req, master_2_cmd, master_2_ack;
    logic [31:0] master_2_addr, master_2_wdata, master_2_rdata;
    logic        slave_req, slave_cmd, slave_ack;
    logic [31:0] slave_addr, slave_wdata, slave_rdata;
    logic [1:0]  grant;
    logic        timeout_flag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    slave_port_arbiter #(
        .SLAVE_ID       (0),
        .SEL_BIT        (31),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .master_1_req   (master_1_req),
        .master_1_addr  (master_1_addr),
        .master_1_cmd   (master_1_cmd),
        .master_1_wdata (master_1_wdata),
        .master_1_ack   (master_1_ack),
        .master_1_rdata (master_1_rdata),
        .master_2_req   (master_2_req),
        .master_2_addr  (master_2_addr),
        .master_2_cmd   (master_2_cmd),
        .master_2_wdata (master_2_wdata),
        .master_2_ack   (master_2_ack),
        .master_2_rdata (master_2_rdata),
        .slave_req      (slave_req),
        .slave_addr     (slave_addr),
        .slave_cmd      (slave_cmd),
        .slave_wdata    (slave_wdata),
        .slave_ack      (slave_ack),
        .slave_rdata    (slave_rdata),
        .grant          (grant),
        .timeout_flag   (timeout_flag)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        master_1_req = 0; master_1_addr = '0; master_1_cmd = 0; master_1_wdata = '0;
        master_2_req = 0; master_2_addr = '0; master_2_cmd = 0; master_2_wdata = '0;
        slave_ack = 0; slave_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        master_1_req = 1; master_1_addr = 32'h10;
        slave_ack = 1; slave_rdata = 32'h5555_AAAA;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({slave_req, slave_addr, slave_cmd, slave_wdata} !== 66'd0) begin
            failures++;
            $display("FAIL reset_slave_side got=%h want=0", {slave_req, slave_addr, slave_cmd, slave_wdata});
        end
        checks++;
        if ({master_1_ack, master_1_rdata, master_2_ack, master_2_rdata} !== 66'd0) begin
            failures++;
            $display("FAIL reset_master_side got=%h want=0", {master_1_ack, master_1_rdata, master_2_ack, master_2_rdata});
        end
        checks++;
        if ({grant, timeout_flag} !== 3'b000) begin
            failures++;
            $display("FAIL reset_grant_flag got=%b want=000", {grant, timeout_flag});
        end
        clear_inputs();
        resetn = 1;
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        master_1_req = 1; master_1_addr = 32'h0000_0010; master_1_cmd = 0;
        @(negedge clk);
        checks++;
        if (slave_req !== 1'b0) begin
            failures++;
            $display("FAIL single_read_pre got slave_req=%b want=0", slave_req);
        end
        tick();
        @(negedge clk);
        checks++;
        if (slave_req !== 1'b1 || grant !== 2'b01 || slave_addr !== 32'h10 || slave_cmd !== 1'b0) begin
            failures++;
            $display("FAIL single_read_grant got req=%b grant=%b addr=%h cmd=%b want 1 01 00000010 0",
                     slave_req, grant, slave_addr, slave_cmd);
        end
        tick();
        @(negedge clk);
        checks++;
        if (master_1_ack !== 1'b0 || slave_req !== 1'b1) begin
            failures++;
            $display("FAIL single_read_wait got ack=%b req=%b want 0 1", master_1_ack, slave_req);
        end
        tick();
        slave_ack = 1; slave_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (master_1_ack !== 1'b1 || master_1_rdata !== 32'h1234_5678 || master_2_ack !== 1'b0 || master_2_rdata !== 32'h0) begin
            failures++;
            $display("FAIL single_read_ack got m1=%b/%h m2=%b/%h want 1/12345678 0/0",
                     master_1_ack, master_1_rdata, master_2_ack, master_2_rdata);
        end
        $display("single_read: m1 addr=%h rdata=%h", master_1_addr, master_1_rdata);
        tick();
        slave_ack = 0; master_1_req = 0;
        @(negedge clk);
        checks++;
        if (slave_req !== 1'b0 || grant !== 2'b00 || master_1_ack !== 1'b0) begin
            failures++;
            $display("FAIL single_read_release got req=%b grant=%b ack=%b want 0 00 0", slave_req, grant, master_1_ack);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        master_1_req = 1; master_1_addr = 32'h20; master_1_cmd = 1; master_1_wdata = 32'hA1;
        master_2_req = 1; master_2_addr = 32'h24; master_2_cmd = 1; master_2_wdata = 32'hB2;
        tick();
        slave_ack = 1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01 || slave_wdata !== 32'hA1 || slave_cmd !== 1'b1 || master_1_ack !== 1'b1 || master_2_ack !== 1'b0) begin
            failures++;
            $display("FAIL simul_first got grant=%b wdata=%h cmd=%b acks=%b%b want 01 000000a1 1 10",
                     grant, slave_wdata, slave_cmd, master_1_ack, master_2_ack);
        end
        $display("simultaneous: write wdata=%h grant=%b", slave_wdata, grant);
        tick();
        slave_ack = 0; master_1_req = 0;
        @(negedge clk);
        checks++;
        if (slave_req !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL simul_gap got req=%b grant=%b want 0 00", slave_req, grant);
        end
        tick();
        slave_ack = 1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || slave_wdata !== 32'hB2 || slave_addr !== 32'h24 || master_2_ack !== 1'b1 || master_1_ack !== 1'b0) begin
            failures++;
            $display("FAIL simul_second got grant=%b wdata=%h addr=%h acks=%b%b want 10 000000b2 00000024 01",
                     grant, slave_wdata, slave_addr, master_1_ack, master_2_ack);
        end
        $display("simultaneous: write wdata=%h grant=%b", slave_wdata, grant);
        // Master 2 was served last, so master 1 is preferred on the next tie.
        tick();
        slave_ack = 0; master_1_req = 1; master_2_req = 1;
        tick();
        slave_ack = 1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL simul_tie_after_m2 got grant=%b want=01", grant);
        end
        // Master 1 just served; with both still requesting master 2 must win.
        tick();
        slave_ack = 0;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL simul_tie_after_m1 got grant=%b want=10", grant);
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        int cnt1 = 0;
        int cnt2 = 0;
        int expect_m = 1;
        do_reset();
        master_1_req = 1; master_1_addr = 32'h100; master_1_cmd = 1; master_1_wdata = 32'h11;
        master_2_req = 1; master_2_addr = 32'h104; master_2_cmd = 1; master_2_wdata = 32'h22;
        for (int c = 0; c < 100 && !(cnt1 == 8 && cnt2 == 8); c++) begin
            @(negedge clk);
            if (slave_req === 1'b1) begin
                slave_ack = 1; slave_rdata = 32'hF000_0000 + 32'(c);
                #1;
                checks++;
                if (grant !== (expect_m == 1 ? 2'b01 : 2'b10) || master_1_ack !== (expect_m == 1) || master_2_ack !== (expect_m == 2)) begin
                    failures++;
                    $display("FAIL fairness_turn cycle=%0d got grant=%b acks=%b%b want master %0d",
                             c, grant, master_1_ack, master_2_ack, expect_m);
                end
                if (master_1_ack === 1'b1) cnt1++;
                if (master_2_ack === 1'b1) cnt2++;
                expect_m = 3 - expect_m;
            end
            tick();
            slave_ack = 0;
            master_1_req = (cnt1 < 8);
            master_2_req = (cnt2 < 8);
        end
        checks++;
        if (cnt1 != 8 || cnt2 != 8) begin
            failures++;
            $display("FAIL fairness_counts got m1=%0d m2=%0d want 8 8", cnt1, cnt2);
        end
        $display("fairness: m1 acks=%0d m2 acks=%0d", cnt1, cnt2);
        clear_inputs();
    endtask

    task automatic test_decode_filter();
        do_reset();
        master_2_req = 1; master_2_addr = 32'h8000_0000; master_2_cmd = 0;
        for (int c = 0; c < 20; c++) begin
            slave_ack = (c % 3 == 1);
            slave_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (slave_req !== 1'b0 || master_2_ack !== 1'b0 || master_1_ack !== 1'b0 || grant !== 2'b00 || master_2_rdata !== 32'h0) begin
                failures++;
                $display("FAIL decode_filter cycle=%0d got req=%b acks=%b%b grant=%b rd2=%h want 0 00 00 0",
                         c, slave_req, master_1_ack, master_2_ack, grant, master_2_rdata);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        // Serve master 1 so the preference moves to master 2.
        master_1_req = 1; master_1_addr = 32'h40;
        tick();
        slave_ack = 1;
        tick();
        slave_ack = 0; master_1_req = 0;
        master_2_req = 1; master_2_addr = 32'h44;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || slave_req !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre got grant=%b req=%b want 10 1", grant, slave_req);
        end
        resetn = 0;
        tick();
        resetn = 1; master_2_req = 0;
        slave_ack = 1; slave_rdata = 32'hCAFE_0001;
        @(negedge clk);
        checks++;
        if (slave_req !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL midreset_idle got req=%b grant=%b want 0 00", slave_req, grant);
        end
        checks++;
        if (master_2_ack !== 1'b0 || master_2_rdata !== 32'h0 || master_1_ack !== 1'b0) begin
            failures++;
            $display("FAIL midreset_late_ack got m2=%b/%h m1=%b want 0/0 0", master_2_ack, master_2_rdata, master_1_ack);
        end
        tick();
        slave_ack = 0;
        master_1_req = 1; master_1_addr = 32'h48;
        master_2_req = 1; master_2_addr = 32'h4C;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL midreset_prio got grant=%b want=01", grant);
        end
        clear_inputs();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int busy_n = 0;
        bit seen = 0;
        // Slave ack landing in the expiry cycle wins over the watchdog.
        do_reset();
        master_1_req = 1; master_1_addr = 32'h50;
        tick();
        for (int c = 0; c < TMO - 1; c++) tick();
        slave_ack = 1; slave_rdata = 32'h0000_0055;
        @(negedge clk);
        checks++;
        if (master_1_ack !== 1'b1 || master_1_rdata !== 32'h55) begin
            failures++;
            $display("FAIL timeout_race_ack got %b/%h want 1/00000055", master_1_ack, master_1_rdata);
        end
        tick();
        slave_ack = 0; master_1_req = 0;
        @(negedge clk);
        checks++;
        if (timeout_flag !== 1'b0) begin
            failures++;
            $display("FAIL timeout_race_flag got=%b want=0", timeout_flag);
        end
        // Silent slave: watchdog must answer in the 8th BUSY cycle.
        master_1_req = 1; master_1_addr = 32'h54;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            @(negedge clk);
            if (slave_req === 1'b1) busy_n++;
            if (master_1_ack === 1'b1) begin
                seen = 1;
                checks++;
                if (busy_n != TMO || master_1_rdata !== BEEF || timeout_flag !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_ack got busy=%0d rdata=%h flag=%b want %0d deadbeef 0",
                             busy_n, master_1_rdata, timeout_flag, TMO);
                end
                $display("timeout: m1 ack after %0d busy cycles rdata=%h", busy_n, master_1_rdata);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_no_ack got no ack in 40 cycles want ack");
        end
        tick();
        master_1_req = 0;
        @(negedge clk);
        checks++;
        if (timeout_flag !== 1'b1 || slave_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_flag_set got flag=%b req=%b want 1 0", timeout_flag, slave_req);
        end
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        checks++;
        if (timeout_flag !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag_sticky got=%b want=1", timeout_flag);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (timeout_flag !== 1'b0) begin
            failures++;
            $display("FAIL timeout_flag_reset got=%b want=0", timeout_flag);
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        master_1_req = 1; master_1_addr = 32'h54;
        for (int c = 0; c < 3 * TMO; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (master_1_ack !== 1'b0 || timeout_flag !== 1'b0 || slave_req !== 1'b1) begin
                failures++;
                $display("FAIL no_watchdog cycle=%0d got ack=%b flag=%b req=%b want 0 0 1",
                         c, master_1_ack, timeout_flag, slave_req);
            end
        end
        clear_inputs();
    endtask
`endif

    // Randomized run against a transaction-level model: who owns the port,
    // who is preferred next, and how long the current owner has waited.
    task automatic test_random();
        int owner = 0;
        int pref = 1;
        int busy_cyc = 0;
        bit flag = 0;
        bit hit1, hit2, tmo, done;
        logic [31:0] e_addr, e_wdata, e_rd1, e_rd2;
        logic        e_cmd, e_ack1, e_ack2;
        logic [1:0]  e_grant;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            master_1_req   = ($urandom_range(0, 3) != 0);
            master_1_addr  = {($urandom_range(0, 3) == 0), 31'($urandom)};
            master_1_cmd   = 1'($urandom);
            master_1_wdata = $urandom;
            master_2_req   = ($urandom_range(0, 3) != 0);
            master_2_addr  = {($urandom_range(0, 3) == 0), 31'($urandom)};
            master_2_cmd   = 1'($urandom);
            master_2_wdata = $urandom;
            slave_ack      = ($urandom_range(0, 2) == 0);
            slave_rdata    = $urandom;

            hit1 = master_1_req && (master_1_addr[31] == 1'b0);
            hit2 = master_2_req && (master_2_addr[31] == 1'b0);
            tmo = 0;
`ifdef ARB_TIMEOUT_EN
            tmo = (owner != 0) && !slave_ack && (busy_cyc == TMO - 1);
`endif
            done    = (owner != 0) && (slave_ack || tmo);
            e_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            e_addr  = (owner == 1) ? master_1_addr  : (owner == 2) ? master_2_addr  : 32'h0;
            e_wdata = (owner == 1) ? master_1_wdata : (owner == 2) ? master_2_wdata : 32'h0;
            e_cmd   = (owner == 1) ? master_1_cmd   : (owner == 2) ? master_2_cmd   : 1'b0;
            e_ack1  = (owner == 1) && done;
            e_ack2  = (owner == 2) && done;
            e_rd1   = (owner == 1) ? (tmo ? BEEF : slave_rdata) : 32'h0;
            e_rd2   = (owner == 2) ? (tmo ? BEEF : slave_rdata) : 32'h0;

            @(negedge clk);
            checks++;
            if ({slave_req, slave_addr, slave_cmd, slave_wdata, grant} !== {(owner != 0), e_addr, e_cmd, e_wdata, e_grant}) begin
                failures++;
                $display("FAIL random_slave_side cycle=%0d got=%h want=%h", c,
                         {slave_req, slave_addr, slave_cmd, slave_wdata, grant},
                         {(owner != 0), e_addr, e_cmd, e_wdata, e_grant});
            end
            checks++;
            if ({master_1_ack, master_1_rdata, master_2_ack, master_2_rdata} !== {e_ack1, e_rd1, e_ack2, e_rd2}) begin
                failures++;
                $display("FAIL random_master_side cycle=%0d got=%h want=%h", c,
                         {master_1_ack, master_1_rdata, master_2_ack, master_2_rdata},
                         {e_ack1, e_rd1, e_ack2, e_rd2});
            end
            checks++;
            if (timeout_flag !== flag) begin
                failures++;
                $display("FAIL random_flag cycle=%0d got=%b want=%b", c, timeout_flag, flag);
            end

            @(posedge clk);
            if (owner == 0) begin
                if (hit1 && hit2) owner = pref;
                else if (hit1)    owner = 1;
                else if (hit2)    owner = 2;
                busy_cyc = 0;
            end else if (done) begin
                pref  = (owner == 1) ? 2 : 1;
                owner = 0;
                if (tmo) flag = 1;
            end else begin
                busy_cyc++;
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_decode_filter();
        test_reset_mid_busy();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit got no finish want finish before 2ms");
        $fatal(1, "time limit");
    end

endmodule
